fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, PC and instruction memory address width.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 32, fetched instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-004 SHALL have one clock and one reset:
- clk  input  1  sole clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have the following ports:
- stall  input  1  hold PC and the decode-side register.
- redirect  input  1  taken branch/jump; load redirect_pc.
- redirect_pc  input  ADDRESS_WIDTH  redirect target byte address.
- imem_addr  output  ADDRESS_WIDTH  byte address to the instruction memory A port.
- imem_rd  input  INSTRUCTION_WIDTH  instruction word returned asynchronously by the instruction memory.
- id_instr  output  INSTRUCTION_WIDTH  registered instruction to decode.
- id_pc  output  ADDRESS_WIDTH  PC of id_instr.
- id_pc_plus4  output  ADDRESS_WIDTH  id_pc + 4.
- id_valid  output  1  id_instr holds a real instruction.
- fault  output  1  sticky misaligned-redirect flag.
- fault_addr  output  ADDRESS_WIDTH  offending redirect_pc.
- fetch_count  output  32  number of instructions delivered.

Function
REQ-006 SHALL drive imem_addr combinationally from the PC register (pc_q) at all times, including during stall and FAULT.
REQ-007 SHALL implement the FSM states BOOT, RUN and FAULT; reset enters BOOT.
REQ-008 In BOOT, SHALL hold pc_q, keep id_valid=0, and move to RUN after exactly one cycle, ignoring stall and redirect.
REQ-009 In RUN, SHALL apply the priority rst > redirect > stall > normal fetch.
REQ-010 On normal fetch, SHALL perform the following in a single edge:
- id_instr<=imem_rd, id_pc<=pc_q, id_pc_plus4<=pc_q+4.
- id_valid<=1.
- pc_q<=pc_q+4.
- fetch_count<=fetch_count+1.
REQ-011 On stall without redirect, SHALL hold pc_q, id_instr, id_pc, id_pc_plus4, id_valid and fetch_count unchanged.
REQ-012 On redirect with redirect_pc[1:0]==2'b00, SHALL perform the following even if stall=1:
- pc_q<=redirect_pc.
- flush: id_valid<=0, id_instr<=32'h0000_0013 (NOP).
- fetch_count unchanged.
REQ-013 On redirect with redirect_pc[1:0]!=2'b00, SHALL perform the following:
- enter FAULT.
- fault<=1, fault_addr<=redirect_pc.
- id_valid<=0, id_instr<=NOP.
- pc_q unchanged.
REQ-014 In FAULT, SHALL hold all registers, keep id_valid=0, ignore stall and redirect, and leave only on rst.
REQ-015 SHALL compute all PC arithmetic modulo 2^ADDRESS_WIDTH, so that 32'hFFFF_FFFC+4 = 32'h0000_0000 with no flag raised.
REQ-016 SHALL wrap fetch_count from 32'hFFFF_FFFF to 0.
REQ-017 Latency: an instruction at pc_q SHALL appear on id_instr/id_valid one cycle after the edge that sampled it.

Reset
REQ-018 On rst=1 at a rising edge, SHALL set the following regardless of state or other inputs, including mid-stall and mid-FAULT:
- pc_q=RESET_PC, state=BOOT.
- id_valid=0, id_instr=32'h0000_0013, id_pc=0, id_pc_plus4=0.
- fault=0, fault_addr=0, fetch_count=0.
REQ-019 SHALL make no output depend on asynchronous reset behaviour.

Verification
REQ-020 Reset then free-run with imem_rd = a word derived from the address -> imem_addr holds 0 for the reset cycle and the BOOT cycle, then 0,4,8; id_pc = 0,4,8 with id_valid=1 starting the cycle after the first RUN edge; fetch_count = 1,2,3.
REQ-021 Stall=1 for 3 cycles at pc_q=8 -> imem_addr stays 8 and id_* and fetch_count are frozen; on release, id_pc=8 on the next edge.
REQ-022 Redirect to 32'h0000_0040 with stall=1 at the same edge -> pc_q=0x40, id_valid=0, id_instr=0x00000013; the next edge gives id_pc=0x40, id_valid=1.
REQ-023 Redirect to 32'h0000_0042 -> fault=1, fault_addr=0x42, id_valid=0 thereafter; later redirects and stall have no effect; rst clears to BOOT with pc_q=0.
REQ-024 Redirect to 32'hFFFF_FFFC then one fetch -> id_pc_plus4=0, pc_q=0.
REQ-025 rst asserted while stall=1 and id_valid=1 -> the next edge gives id_valid=0, pc_q=RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register drives imem_addr combinationally; the returned word lands in the decode register one edge later.
// stall freezes PC and decode register; redirect flushes and wins over stall; a misaligned redirect locks in FAULT until rst.
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH     = 32,
  parameter int                       INSTRUCTION_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC          = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_pc,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rd,
  output logic [INSTRUCTION_WIDTH-1:0] id_instr,
  output logic [ADDRESS_WIDTH-1:0]     id_pc,
  output logic [ADDRESS_WIDTH-1:0]     id_pc_plus4,
  output logic                         id_valid,
  output logic                         fault,
  output logic [ADDRESS_WIDTH-1:0]     fault_addr,
  output logic [31:0]                  fetch_count
);

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP  = INSTRUCTION_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0]     STEP = ADDRESS_WIDTH'(4);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [ADDRESS_WIDTH-1:0]     pc;
    logic [ADDRESS_WIDTH-1:0]     pc_plus4;
    logic                         valid;
  } id_reg_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  id_reg_t                  id_q, id_d;
  logic                     fault_q, fault_d;
  logic [ADDRESS_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic [31:0]              count_q, count_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_d         = id_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    count_d      = count_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          id_d.valid = 1'b0;
          id_d.instr = NOP;
          if (redirect_pc[1:0] == 2'b00) begin
            pc_d = redirect_pc;
          end else begin
            // misaligned target: keep the old PC so imem_addr stays a legal address
            state_d      = FAULT;
            fault_d      = 1'b1;
            fault_addr_d = redirect_pc;
          end
        end else if (!stall) begin
          id_d.instr    = imem_rd;
          id_d.pc       = pc_q;
          id_d.pc_plus4 = pc_q + STEP;
          id_d.valid    = 1'b1;
          pc_d          = pc_q + STEP;
          count_d       = count_q + 32'd1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      id_q.instr   <= NOP;
      id_q.pc      <= '0;
      id_q.pc_plus4 <= '0;
      id_q.valid   <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_q         <= id_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = id_q.instr;
  assign id_pc       = id_q.pc;
  assign id_pc_plus4 = id_q.pc_plus4;
  assign id_valid    = id_q.valid;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; instruction memory returns address ^ 32'hC0DE_0000.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rd = imem_addr ^ 32'hC0DE_0000;

  fetch_stage #(
    .ADDRESS_WIDTH    (32),
    .INSTRUCTION_WIDTH(32),
    .RESET_PC         (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_valid   (id_valid),
    .fault      (fault),
    .fault_addr (fault_addr),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0080;
    #2;
    step();
    check("rst_addr",   imem_addr,   32'h0);
    check("rst_valid",  id_valid,    32'h0);
    check("rst_instr",  id_instr,    32'h0000_0013);
    check("rst_pc",     id_pc,       32'h0);
    check("rst_pc4",    id_pc_plus4, 32'h0);
    check("rst_fault",  fault,       32'h0);
    check("rst_faddr",  fault_addr,  32'h0);
    check("rst_count",  fetch_count, 32'h0);

    // BOOT must ignore the pending redirect and stall
    rst = 1'b0;
    step();
    check("boot_addr",  imem_addr,   32'h0);
    check("boot_valid", id_valid,    32'h0);
    check("boot_count", fetch_count, 32'h0);
    redirect = 1'b0; stall = 1'b0;

    step();
    check("f0_pc",    id_pc,       32'h0);
    check("f0_valid", id_valid,    32'h1);
    check("f0_instr", id_instr,    32'hC0DE_0000);
    check("f0_pc4",   id_pc_plus4, 32'h4);
    check("f0_count", fetch_count, 32'h1);
    check("f0_addr",  imem_addr,   32'h4);

    step();
    check("f1_pc",    id_pc,       32'h4);
    check("f1_count", fetch_count, 32'h2);
    check("f1_addr",  imem_addr,   32'h8);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr",  imem_addr,   32'h8);
      check("stall_pc",    id_pc,       32'h4);
      check("stall_instr", id_instr,    32'hC0DE_0004);
      check("stall_count", fetch_count, 32'h2);
      check("stall_valid", id_valid,    32'h1);
    end
    stall = 1'b0;
    step();
    check("rel_pc",    id_pc,       32'h8);
    check("rel_instr", id_instr,    32'hC0DE_0008);
    check("rel_count", fetch_count, 32'h3);

    // redirect wins over a simultaneous stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
    step();
    check("rd_addr",  imem_addr,   32'h40);
    check("rd_valid", id_valid,    32'h0);
    check("rd_instr", id_instr,    32'h0000_0013);
    check("rd_count", fetch_count, 32'h3);
    stall = 1'b0; redirect = 1'b0;
    step();
    check("rd_f_pc",    id_pc,       32'h40);
    check("rd_f_valid", id_valid,    32'h1);
    check("rd_f_instr", id_instr,    32'hC0DE_0040);
    check("rd_f_count", fetch_count, 32'h4);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_pc",    id_pc,       32'hFFFF_FFFC);
    check("wrap_pc4",   id_pc_plus4, 32'h0);
    check("wrap_addr",  imem_addr,   32'h0);
    check("wrap_fault", fault,       32'h0);
    check("wrap_count", fetch_count, 32'h5);
    step();
    check("post_wrap_pc",   id_pc,     32'h0);
    check("post_wrap_addr", imem_addr, 32'h4);

    // reset while stalled with a valid instruction in decode
    stall = 1'b1; rst = 1'b1;
    step();
    check("rs_valid", id_valid,    32'h0);
    check("rs_addr",  imem_addr,   32'h0);
    check("rs_count", fetch_count, 32'h0);
    check("rs_pc",    id_pc,       32'h0);
    rst = 1'b0; stall = 1'b0;
    step();
    step();
    check("rs_f_pc",    id_pc,       32'h0);
    check("rs_f_count", fetch_count, 32'h1);
    check("rs_f_addr",  imem_addr,   32'h4);

    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    step();
    check("flt",       fault,       32'h1);
    check("flt_addr",  fault_addr,  32'h42);
    check("flt_valid", id_valid,    32'h0);
    check("flt_instr", id_instr,    32'h0000_0013);
    check("flt_pc",    imem_addr,   32'h4);
    redirect_pc = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      step();
      check("flt_hold_addr",  imem_addr,   32'h4);
      check("flt_hold_faddr", fault_addr,  32'h42);
      check("flt_hold_valid", id_valid,    32'h0);
      check("flt_hold_count", fetch_count, 32'h1);
    end
    redirect = 1'b0; stall = 1'b0;
    step();
    check("flt_run_valid", id_valid,    32'h0);
    check("flt_run_addr",  imem_addr,   32'h4);
    check("flt_run_fault", fault,       32'h1);
    rst = 1'b1;
    step();
    check("flt_rst_fault", fault,      32'h0);
    check("flt_rst_faddr", fault_addr, 32'h0);
    check("flt_rst_addr",  imem_addr,  32'h0);
    rst = 1'b0;
    step();
    check("flt_boot_valid", id_valid, 32'h0);
    step();
    check("flt_rec_valid", id_valid, 32'h1);
    check("flt_rec_pc",    id_pc,    32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
